// File: rtl/avsdpll_fll_ctrl.sv
// Digital frequency-lock loop controller for the DCO.
// Counts DCO clock cycles per reference period and compares the count with the
// multiplier B. It then steers a saturating control word toward CLK = B * REF.
// It also reports lock, loss of reference and the signed frequency error.
module avsdpll_fll_ctrl #(
  parameter int DIV_W      = 4,
  parameter int CTRL_W     = 8,
  parameter int CTRL_INIT  = 128,
  parameter int GAIN_SHIFT = 1,
  parameter int LOCK_TOL   = 0,
  parameter int LOCK_COUNT = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    EN,
  input  logic                    HOLD,
  input  logic                    REF,
  input  logic [DIV_W-1:0]        B,
  output logic [CTRL_W-1:0]       DCO_CTRL,
  output logic signed [DIV_W+2:0] ERR,
  output logic                    MEAS_VALID,
  output logic                    LOCK,
  output logic                    REF_LOST
);

  localparam int CNT_W  = DIV_W + 2;
  localparam int SUM_W  = ((CTRL_W > CNT_W) ? CTRL_W : CNT_W) + 2;
  localparam int LCNT_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]        CNT_MAX  = '1;
  localparam logic [CNT_W:0]          TOL      = (CNT_W + 1)'(LOCK_TOL);
  localparam logic signed [SUM_W-1:0] DCO_MAX  = SUM_W'((1 << CTRL_W) - 1);
  localparam logic [CTRL_W-1:0]       DCO_INIT = CTRL_W'(CTRL_INIT);
  localparam logic [LCNT_W-1:0]       LCNT_TGT = LCNT_W'(LOCK_COUNT);

  typedef enum logic [1:0] {ST_OFF, ST_WAIT, ST_TRACK, ST_LOCKED} state_t;

  state_t state_q, state_d;

  logic ref_s1_q, ref_s1_d;
  logic ref_s2_q, ref_s2_d;
  logic ref_s3_q, ref_s3_d;
  logic ref_pulse_q, ref_pulse_d;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        meas_q, meas_d;
  logic                    pend_q, pend_d;
  logic signed [CNT_W:0]   err_q, err_d;
  logic [CTRL_W-1:0]       dco_q, dco_d;
  logic                    valid_q, valid_d;
  logic                    lost_q, lost_d;
  logic [LCNT_W-1:0]       lcnt_q, lcnt_d;

  logic signed [CNT_W:0]   err_v;
  logic signed [CNT_W:0]   step_v;
  logic signed [SUM_W-1:0] sum_v;
  logic [CTRL_W-1:0]       dco_sat;
  logic [CNT_W:0]          abs_v;
  logic                    in_tol;
  logic                    b_ok;
  logic                    timeout;
  logic [LCNT_W-1:0]       lcnt_inc;

  // Synchronise REF into the CLK domain and register a one-cycle rising-edge pulse
  always_comb begin
    ref_s1_d    = REF;
    ref_s2_d    = ref_s1_q;
    ref_s3_d    = ref_s2_q;
    ref_pulse_d = ref_s2_q & ~ref_s3_q;
  end

  // Error, loop step, saturated control word and lock tolerance for the pending measurement
  always_comb begin
    err_v    = $signed({{(CNT_W + 1 - DIV_W){1'b0}}, B}) - $signed({1'b0, meas_q});
    step_v   = err_v >>> GAIN_SHIFT;
    sum_v    = SUM_W'($signed({1'b0, dco_q})) + SUM_W'(step_v);
    dco_sat  = sum_v[CTRL_W-1:0];
    if (sum_v[SUM_W-1]) begin
      dco_sat = '0;
    end else if (sum_v > DCO_MAX) begin
      dco_sat = '1;
    end
    abs_v    = err_v[CNT_W] ? $unsigned(-err_v) : $unsigned(err_v);
    in_tol   = (abs_v <= TOL);
    b_ok     = (B > DIV_W'(1));
    timeout  = (cnt_q == CNT_MAX);
    lcnt_inc = lcnt_q + 1'b1;
  end

  // Loop state machine, period counter and update step
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    meas_d  = meas_q;
    pend_d  = 1'b0;
    err_d   = err_q;
    dco_d   = dco_q;
    valid_d = 1'b0;
    lost_d  = lost_q;
    lcnt_d  = lcnt_q;

    // Free-running period counter: restarts at 1 on each pulse, saturates at CNT_MAX
    if (ref_pulse_q) begin
      meas_d = cnt_q;
      cnt_d  = CNT_W'(1);
    end else if (!timeout) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      ST_OFF: begin
        cnt_d = '0;
        if (EN) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // First edge after enable or after a timeout only arms the counter
        if (ref_pulse_q) begin
          state_d = ST_TRACK;
          lost_d  = 1'b0;
        end
      end
      ST_TRACK, ST_LOCKED: begin
        if (ref_pulse_q) begin
          if (timeout) begin
            // Period too long to be trusted: drop it and restart lock qualification
            state_d = ST_TRACK;
            lcnt_d  = '0;
          end else begin
            pend_d = 1'b1;
          end
        end else if (timeout) begin
          lost_d  = 1'b1;
          state_d = ST_WAIT;
          lcnt_d  = '0;
        end else if (pend_q) begin
          valid_d = 1'b1;
          err_d   = err_v;
          if (!b_ok) begin
            state_d = ST_TRACK;
            lcnt_d  = '0;
          end else begin
            if (!HOLD) begin
              dco_d = dco_sat;
            end
            if (!in_tol) begin
              state_d = ST_TRACK;
              lcnt_d  = '0;
            end else if (state_q == ST_TRACK) begin
              lcnt_d = lcnt_inc;
              if (lcnt_inc >= LCNT_TGT) begin
                state_d = ST_LOCKED;
              end
            end
          end
        end
      end
      default: state_d = ST_OFF;
    endcase

    // Disable overrides everything and parks the loop at its initial word
    if (!EN) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      pend_d  = 1'b0;
      valid_d = 1'b0;
      dco_d   = DCO_INIT;
      lost_d  = 1'b0;
      lcnt_d  = '0;
    end
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_OFF;
      ref_s1_q    <= 1'b0;
      ref_s2_q    <= 1'b0;
      ref_s3_q    <= 1'b0;
      ref_pulse_q <= 1'b0;
      cnt_q       <= '0;
      meas_q      <= '0;
      pend_q      <= 1'b0;
      err_q       <= '0;
      dco_q       <= DCO_INIT;
      valid_q     <= 1'b0;
      lost_q      <= 1'b0;
      lcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      ref_s1_q    <= ref_s1_d;
      ref_s2_q    <= ref_s2_d;
      ref_s3_q    <= ref_s3_d;
      ref_pulse_q <= ref_pulse_d;
      cnt_q       <= cnt_d;
      meas_q      <= meas_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
      dco_q       <= dco_d;
      valid_q     <= valid_d;
      lost_q      <= lost_d;
      lcnt_q      <= lcnt_d;
    end
  end

  assign DCO_CTRL   = dco_q;
  assign ERR        = err_q;
  assign MEAS_VALID = valid_q;
  assign LOCK       = (state_q == ST_LOCKED);
  assign REF_LOST   = lost_q;

endmodule

// File: tb/tb_avsdpll_fll_ctrl.sv
// Testbench for avsdpll_fll_ctrl: REF edges are scheduled on whole CLK cycles.
// A reference model predicts every measurement from the spacing of those edges.
// A monitor then compares each MEAS_VALID against the predictions in a queue.
module tb_avsdpll_fll_ctrl;

  localparam int CTRL_INIT  = 128;
  localparam int CNT_MAX    = 63;
  localparam int LOCK_COUNT = 4;
  localparam int LOCK_TOL   = 0;
  localparam int GAIN_SHIFT = 1;
  localparam int LATENCY    = 5;

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b0;
  logic       EN    = 1'b0;
  logic       HOLD  = 1'b0;
  logic       REF   = 1'b0;
  logic [3:0] B     = 4'd0;
  logic [7:0] DCO_CTRL;
  logic signed [6:0] ERR;
  logic       MEAS_VALID;
  logic       LOCK;
  logic       REF_LOST;

  avsdpll_fll_ctrl dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .EN         (EN),
    .HOLD       (HOLD),
    .REF        (REF),
    .B          (B),
    .DCO_CTRL   (DCO_CTRL),
    .ERR        (ERR),
    .MEAS_VALID (MEAS_VALID),
    .LOCK       (LOCK),
    .REF_LOST   (REF_LOST)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int err;
    int dco;
    bit lock;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_en;
  bit m_armed;
  bit m_locked;
  int m_lcnt;
  int m_dco;
  int m_prev;
  int last_rise;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Floor division by 2^GAIN_SHIFT
  function automatic int floor_step(input int e);
    int d;
    d = 1 << GAIN_SHIFT;
    if (e >= 0) return e / d;
    return -((-e + d - 1) / d);
  endfunction

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic model_off();
    m_armed  = 1'b0;
    m_locked = 1'b0;
    m_lcnt   = 0;
    m_dco    = CTRL_INIT;
  endtask

  // Predict the effect of a REF rise seen at cycle n
  task automatic model_rise(input int n);
    int d;
    int e;
    if (!m_en) return;
    if (!m_armed) begin
      m_armed = 1'b1;
      m_prev  = n;
      return;
    end
    d      = n - m_prev;
    m_prev = n;
    if (d >= CNT_MAX) begin
      // Either a timeout already re-armed the loop, or the period saturated
      m_locked = 1'b0;
      m_lcnt   = 0;
      return;
    end
    e = int'(B) - d;
    if (int'(B) < 2) begin
      m_locked = 1'b0;
      m_lcnt   = 0;
    end else begin
      if (!HOLD) m_dco = clamp(m_dco + floor_step(e));
      if ((e < 0 ? -e : e) <= LOCK_TOL) begin
        if (!m_locked) begin
          m_lcnt++;
          if (m_lcnt >= LOCK_COUNT) m_locked = 1'b1;
        end
      end else begin
        m_locked = 1'b0;
        m_lcnt   = 0;
      end
    end
    q.push_back('{n + LATENCY, e, m_dco, m_locked});
  endtask

  // One REF period of p cycles; caller is at a negedge, returns at a negedge
  task automatic rise(input int p);
    int hi;
    hi = p / 2;
    REF = 1'b1;
    last_rise = cyc;
    model_rise(cyc);
    repeat (hi) @(negedge CLK);
    REF = 1'b0;
    repeat (p - hi) @(negedge CLK);
  endtask

  // Monitor: every MEAS_VALID must match the oldest prediction at its cycle
  always @(negedge CLK) begin
    if (RST_N) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL meas_missing: MEAS_VALID absent, expected at cycle %0d", q[0].cyc);
        void'(q.pop_front());
      end
      if (MEAS_VALID) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
          exp_t e;
          e = q.pop_front();
          $display("meas cyc=%0d B=%0d err=%0d dco=%0d lock=%0d", cyc, B,
                   int'(ERR), int'(DCO_CTRL), LOCK);
          chk("err", int'(ERR), e.err);
          chk("dco_ctrl", int'(DCO_CTRL), e.dco);
          chk("lock", int'(LOCK), int'(e.lock));
        end else begin
          checks++;
          errors++;
          $display("FAIL meas_unexpected: MEAS_VALID=1 at cycle %0d, expected 0", cyc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    m_en = 1'b0;
    model_off();
    last_rise = 0;

    // Reset values
    repeat (2) @(negedge CLK);
    chk("rst_dco", int'(DCO_CTRL), CTRL_INIT);
    chk("rst_err", int'(ERR), 0);
    chk("rst_valid", int'(MEAS_VALID), 0);
    chk("rst_lock", int'(LOCK), 0);
    chk("rst_lost", int'(REF_LOST), 0);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("off_dco", int'(DCO_CTRL), CTRL_INIT);

    // B=8, period 10: arming edge, then ERR=-2 and DCO 128->127
    B = 4'd8; EN = 1'b1; m_en = 1'b1;
    repeat (3) rise(10);

    // Period 8 locks after four zero-error measurements, one 9-cycle period unlocks
    repeat (5) rise(8);
    chk("lock_on", int'(LOCK), 1);
    rise(9);
    rise(8);
    chk("lock_off", int'(LOCK), 0);

    // Relock, then HOLD with period 10 freezes DCO but still unlocks
    repeat (4) rise(8);
    chk("relock", int'(LOCK), 1);
    HOLD = 1'b1;
    rise(10);
    rise(10);
    chk("hold_unlock", int'(LOCK), 0);
    chk("hold_dco", int'(DCO_CTRL), m_dco);
    HOLD = 1'b0;

    // Disable returns to the initial word on the next edge
    EN = 1'b0; m_en = 1'b0; model_off();
    @(negedge CLK);
    chk("dis_dco", int'(DCO_CTRL), CTRL_INIT);
    chk("dis_lock", int'(LOCK), 0);

    // Saturation at both ends of the control range
    EN = 1'b1; m_en = 1'b1; B = 4'd15;
    repeat (30) rise(5);
    chk("sat_hi", int'(DCO_CTRL), 255);
    B = 4'd2;
    repeat (55) rise(12);
    chk("sat_lo", int'(DCO_CTRL), 0);

    // B below 2 never updates the word and never locks
    B = 4'd1;
    repeat (3) rise(6);
    B = 4'd0;
    repeat (2) rise(7);
    chk("b_small_lock", int'(LOCK), 0);
    chk("b_small_dco", int'(DCO_CTRL), 0);

    // Loss of reference: timeout 63 cycles after the last pulse
    B = 4'd4;
    repeat (3) rise(6);
    repeat (60) @(negedge CLK);
    chk("lost_early", int'(REF_LOST), 0);
    @(negedge CLK);
    chk("lost_set", int'(REF_LOST), 1);
    chk("lost_lock", int'(LOCK), 0);
    repeat (5) @(negedge CLK);
    chk("lost_dco", int'(DCO_CTRL), m_dco);
    rise(10);
    chk("lost_clear", int'(REF_LOST), 0);
    rise(6);

    // Randomised operation
    for (int i = 0; i < 40; i++) begin
      B    = 4'($urandom_range(0, 15));
      HOLD = ($urandom_range(0, 3) == 0);
      rise(int'($urandom_range(5, 20)));
    end
    HOLD = 1'b0;

    // Reset in the middle of a pending measurement
    B = 4'd8;
    rise(8);
    REF = 1'b1;
    model_rise(cyc);
    @(negedge CLK);
    REF = 1'b0;
    @(negedge CLK);
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    EN = 1'b0; m_en = 1'b0;
    q.delete();
    model_off();
    #1;
    chk("mid_rst_dco", int'(DCO_CTRL), CTRL_INIT);
    chk("mid_rst_lock", int'(LOCK), 0);
    chk("mid_rst_lost", int'(REF_LOST), 0);
    chk("mid_rst_valid", int'(MEAS_VALID), 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    chk("post_rst_dco", int'(DCO_CTRL), CTRL_INIT);
    chk("post_rst_lock", int'(LOCK), 0);

    // Loop runs again after reset
    EN = 1'b1; m_en = 1'b1;
    repeat (3) rise(9);

    repeat (10) @(negedge CLK);
    while (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL meas_drain: prediction for cycle %0d never matched", q[0].cyc);
      void'(q.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
